// File: rtl/encoder_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : encoder_param_ctrl
// Purpose  : Quadrature encoder and pushbutton front end driving a browse/edit
//            parameter-register user interface.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_param_ctrl #(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 256,
   parameter int NUM_PARAMS        = 4,
   parameter int VALUE_W           = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          enc_a,
   input  logic                          enc_b,
   input  logic                          btn_n,
   output logic [$clog2(NUM_PARAMS)-1:0] sel,
   output logic                          edit_mode,
   output logic [VALUE_W-1:0]            value_out,
   output logic                          step_pulse,
   output logic                          step_dir,
   output logic                          short_press,
   output logic                          long_press
);

   localparam int c_sel_w  = $clog2(NUM_PARAMS);
   localparam int c_dbc_w  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_hold_w = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [c_sel_w-1:0]  c_sel_max   = c_sel_w'(NUM_PARAMS - 1);
   localparam logic [c_dbc_w-1:0]  c_dbc_last  = c_dbc_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_hold_w-1:0] c_hold_long = c_hold_w'(LONG_PRESS_CYCLES);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_PRESS_CYCLES - 1);
   localparam logic [VALUE_W-1:0]  c_val_max   = {VALUE_W{1'b1}};

   typedef enum logic [0:0] {
      ST_BROWSE = 1'b0,
      ST_EDIT   = 1'b1
   } state_t;

   logic r_a_meta, r_a_sync, r_a_prev;
   logic r_b_meta, r_b_sync, r_b_prev;
   logic r_btn_meta, r_btn_sync;

   logic [c_dbc_w-1:0]  r_dbc_cnt;
   logic                r_btn_db;
   logic [c_hold_w-1:0] r_hold;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_sel_w-1:0]  r_sel;
   logic [c_sel_w-1:0]  w_sel_nxt;
   logic [VALUE_W-1:0]  r_param [NUM_PARAMS];
   logic [VALUE_W-1:0]  r_shadow;

   logic                w_step, w_step_cw, w_pressed;
   logic                w_short_evt, w_long_evt;
   logic                w_short_acc, w_long_acc, w_step_acc;
   logic                w_clear_all, w_param_we, w_shadow_we;
   logic [VALUE_W-1:0]  w_param_wdata, w_cur;

   // Two-flop synchronizers; the third A/B flop holds the previous sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_meta   <= 1'b0;
         r_a_sync   <= 1'b0;
         r_a_prev   <= 1'b0;
         r_b_meta   <= 1'b0;
         r_b_sync   <= 1'b0;
         r_b_prev   <= 1'b0;
         r_btn_meta <= 1'b1;
         r_btn_sync <= 1'b1;
      end else begin
         r_a_meta   <= enc_a;
         r_a_sync   <= r_a_meta;
         r_a_prev   <= r_a_sync;
         r_b_meta   <= enc_b;
         r_b_sync   <= r_b_meta;
         r_b_prev   <= r_b_sync;
         r_btn_meta <= btn_n;
         r_btn_sync <= r_btn_meta;
      end
   end

   // A rising with B unchanged is a detent; simultaneous A/B change is invalid.
   assign w_step    = r_a_sync & ~r_a_prev & ~(r_b_sync ^ r_b_prev);
   assign w_step_cw = ~r_b_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbc_cnt <= '0;
         r_btn_db  <= 1'b1;
      end else if (r_btn_sync == r_btn_db) begin
         r_dbc_cnt <= '0;
      end else if (r_dbc_cnt == c_dbc_last) begin
         r_btn_db  <= r_btn_sync;
         r_dbc_cnt <= '0;
      end else begin
         r_dbc_cnt <= r_dbc_cnt + 1'b1;
      end
   end

   assign w_pressed = ~r_btn_db;

   // Hold count saturates at the long-press threshold, which also marks the
   // press as consumed so the release stays silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else if (w_pressed) begin
         if (r_hold != c_hold_long) begin
            r_hold <= r_hold + 1'b1;
         end
      end else begin
         r_hold <= '0;
      end
   end

   assign w_long_evt  = w_pressed & (r_hold == c_hold_last);
   assign w_short_evt = ~w_pressed & (r_hold != '0) & (r_hold != c_hold_long);

   assign w_short_acc = ena & w_short_evt;
   assign w_long_acc  = ena & w_long_evt;
   assign w_step_acc  = ena & w_step & ~(w_short_evt | w_long_evt);

   assign w_cur = r_param[r_sel];

   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_clear_all   = 1'b0;
      w_param_we    = 1'b0;
      w_param_wdata = w_cur;
      w_shadow_we   = 1'b0;
      case (r_state)
         ST_BROWSE: begin
            if (w_long_acc) begin
               w_clear_all = 1'b1;
               w_sel_nxt   = '0;
            end else if (w_short_acc) begin
               w_state_nxt = ST_EDIT;
               w_shadow_we = 1'b1;
            end else if (w_step_acc) begin
               if (w_step_cw) begin
                  w_sel_nxt = (r_sel == c_sel_max) ? '0 : r_sel + 1'b1;
               end else begin
                  w_sel_nxt = (r_sel == '0) ? c_sel_max : r_sel - 1'b1;
               end
            end
         end
         ST_EDIT: begin
            if (w_long_acc) begin
               w_param_we    = 1'b1;
               w_param_wdata = r_shadow;
               w_state_nxt   = ST_BROWSE;
            end else if (w_short_acc) begin
               w_state_nxt = ST_BROWSE;
            end else if (w_step_acc) begin
               w_param_we = 1'b1;
               if (w_step_cw) begin
                  w_param_wdata = (w_cur == c_val_max) ? w_cur : w_cur + 1'b1;
               end else begin
                  w_param_wdata = (w_cur == '0) ? w_cur : w_cur - 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_BROWSE;
         r_sel    <= '0;
         r_shadow <= '0;
         for (int i = 0; i < NUM_PARAMS; i++) begin
            r_param[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         if (w_shadow_we) begin
            r_shadow <= w_cur;
         end
         if (w_clear_all) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
               r_param[i] <= '0;
            end
         end else if (w_param_we) begin
            r_param[r_sel] <= w_param_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_pulse  <= 1'b0;
         step_dir    <= 1'b1;
         short_press <= 1'b0;
         long_press  <= 1'b0;
      end else begin
         step_pulse  <= w_step_acc;
         short_press <= w_short_acc;
         long_press  <= w_long_acc;
         if (w_step_acc) begin
            step_dir <= w_step_cw;
         end
      end
   end

   assign sel       = r_sel;
   assign edit_mode = (r_state == ST_EDIT);
   assign value_out = w_cur;

endmodule
`default_nettype wire

// File: tb/tb_encoder_param_ctrl.sv
`default_nettype none
// Bench for encoder_param_ctrl: directed UI scenarios plus random stimulus,
// all checked every cycle against a behavioural model of the user interface.
module tb_encoder_param_ctrl;

   localparam int DEB  = 16;
   localparam int LONG = 256;
   localparam int NP   = 4;
   localparam int VW   = 8;
   localparam int SW   = 2;
   localparam int VMAX = (1 << VW) - 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena   = 1'b0;
   logic          enc_a = 1'b0;
   logic          enc_b = 1'b0;
   logic          btn_n = 1'b1;
   logic [SW-1:0] sel;
   logic          edit_mode;
   logic [VW-1:0] value_out;
   logic          step_pulse, step_dir, short_press, long_press;

   encoder_param_ctrl #(
      .DEBOUNCE_CYCLES  (DEB),
      .LONG_PRESS_CYCLES(LONG),
      .NUM_PARAMS       (NP),
      .VALUE_W          (VW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .btn_n      (btn_n),
      .sel        (sel),
      .edit_mode  (edit_mode),
      .value_out  (value_out),
      .step_pulse (step_pulse),
      .step_dir   (step_dir),
      .short_press(short_press),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_step   = 0;
   int n_short  = 0;
   int n_long   = 0;

   // ---------------- behavioural model ----------------
   // Pad history: the decoder sees each pad value two edges after it is sampled.
   bit m_a1, m_sa, m_sa_prev, m_b1, m_sb, m_sb_prev, m_k1, m_sk;
   bit m_db;             // accepted button level (1 = released)
   int m_run;            // cycles the synced level has disagreed with m_db
   int m_age;            // cycles since accepted press, capped at LONG
   bit m_short_pend;     // release seen on a press that never went long
   bit m_edit;
   int m_sel;
   int m_param [NP];
   int m_shadow;
   bit e_step, e_dir, e_short, e_long;

   task automatic model_reset();
      {m_a1, m_sa, m_sa_prev, m_b1, m_sb, m_sb_prev} = '0;
      m_k1 = 1'b1; m_sk = 1'b1; m_db = 1'b1;
      m_run = 0; m_age = 0; m_short_pend = 1'b0;
      m_edit = 1'b0; m_sel = 0; m_shadow = 0;
      foreach (m_param[i]) m_param[i] = 0;
      e_step = 1'b0; e_dir = 1'b1; e_short = 1'b0; e_long = 1'b0;
   endtask

   task automatic model_clock();
      bit step, cw, sh, lg;
      step = m_sa && !m_sa_prev && (m_sb == m_sb_prev);
      cw   = !m_sb;
      sh = 1'b0; lg = 1'b0;
      if (!m_db) begin
         if (m_age == LONG - 1) lg = 1'b1;
         if (m_age < LONG) m_age++;
      end else begin
         sh = m_short_pend;
         m_short_pend = 1'b0;
         m_age = 0;
      end
      if (m_sk != m_db) begin
         m_run++;
         if (m_run == DEB) begin
            m_db  = m_sk;
            m_run = 0;
            if (m_db && m_age < LONG) m_short_pend = 1'b1;
         end
      end else begin
         m_run = 0;
      end
      e_short = ena && sh;
      e_long  = ena && lg;
      e_step  = ena && step && !(sh || lg);
      if (e_step) e_dir = cw;
      if (e_long) begin
         if (m_edit) begin
            m_param[m_sel] = m_shadow;
            m_edit = 1'b0;
         end else begin
            foreach (m_param[i]) m_param[i] = 0;
            m_sel = 0;
         end
      end else if (e_short) begin
         if (m_edit) begin
            m_edit = 1'b0;
         end else begin
            m_edit   = 1'b1;
            m_shadow = m_param[m_sel];
         end
      end else if (e_step) begin
         if (m_edit) begin
            if (cw) m_param[m_sel] = (m_param[m_sel] < VMAX) ? m_param[m_sel] + 1 : VMAX;
            else    m_param[m_sel] = (m_param[m_sel] > 0) ? m_param[m_sel] - 1 : 0;
         end else begin
            m_sel = (m_sel + (cw ? 1 : NP - 1)) % NP;
         end
      end
      m_sa_prev = m_sa; m_sa = m_a1; m_a1 = enc_a;
      m_sb_prev = m_sb; m_sb = m_b1; m_b1 = enc_b;
      m_sk = m_k1; m_k1 = btn_n;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_clock();
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      logic [SW-1:0] x_sel;
      logic [VW-1:0] x_val;
      #1;
      x_sel = m_sel[SW-1:0];
      x_val = m_param[m_sel][VW-1:0];
      n_checks++;
      if (sel !== x_sel || edit_mode !== m_edit || value_out !== x_val ||
          step_pulse !== e_step || step_dir !== e_dir ||
          short_press !== e_short || long_press !== e_long) begin
         n_fail++;
         $display("FAIL model_cycle t=%0t: got sel=%0d edit=%0b val=%0d step=%0b dir=%0b short=%0b long=%0b; expected sel=%0d edit=%0b val=%0d step=%0b dir=%0b short=%0b long=%0b",
                  $time, sel, edit_mode, value_out, step_pulse, step_dir, short_press, long_press,
                  x_sel, m_edit, x_val, e_step, e_dir, e_short, e_long);
      end
      if (step_pulse === 1'b1)  n_step++;
      if (short_press === 1'b1) n_short++;
      if (long_press === 1'b1)  n_long++;
   end

   task automatic check_lit(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(input bit b, input bit a, input int n);
      enc_b = b; enc_a = a;
      idle(n);
   endtask

   task automatic cw(input int n);
      set_ab(0, 1, n); set_ab(1, 1, n); set_ab(1, 0, n); set_ab(0, 0, n);
   endtask

   task automatic ccw(input int n);
      set_ab(1, 0, n); set_ab(1, 1, n); set_ab(0, 1, n); set_ab(0, 0, n);
   endtask

   task automatic press(input int hold);
      btn_n = 1'b0;
      idle(hold);
      btn_n = 1'b1;
      idle(DEB + 10);
   endtask

   initial begin
      int s_step, s_short, s_long;

      idle(3);
      rst_n = 1'b1;
      idle(2);
      check_lit("reset_sel", sel, 0);
      check_lit("reset_edit", edit_mode, 0);
      check_lit("reset_val", value_out, 0);
      check_lit("reset_dir", step_dir, 1);

      // CW browse
      ena = 1'b1;
      s_step = n_step;
      cw(10); cw(10); idle(5);
      check_lit("cw_pulses", n_step - s_step, 2);
      check_lit("cw_sel", sel, 2);
      check_lit("cw_dir", step_dir, 1);
      check_lit("cw_val", value_out, 0);

      // Long press in BROWSE returns sel to 0, then CCW wraps to 3
      s_long = n_long;
      press(300);
      check_lit("browse_long_pulse", n_long - s_long, 1);
      check_lit("browse_long_sel", sel, 0);
      ccw(10); idle(5);
      check_lit("ccw_sel", sel, 3);
      check_lit("ccw_dir", step_dir, 0);

      // Edit with saturation at both ends
      s_short = n_short;
      press(40);
      check_lit("edit_enter_short", n_short - s_short, 1);
      check_lit("edit_enter_mode", edit_mode, 1);
      s_step = n_step;
      repeat (3) ccw(3);
      idle(4);
      check_lit("sat_low_val", value_out, 0);
      check_lit("sat_low_pulses", n_step - s_step, 3);
      repeat (260) cw(3);
      idle(4);
      check_lit("sat_high_val", value_out, 255);
      press(40);
      check_lit("commit_mode", edit_mode, 0);
      check_lit("commit_val", value_out, 255);

      // Cancel: param[1]=5, edit to 9, long press restores 5
      cw(3); cw(3); idle(4);
      check_lit("cancel_sel", sel, 1);
      press(40);
      repeat (5) cw(3);
      press(40);
      check_lit("p1_commit_val", value_out, 5);
      press(40);
      repeat (4) cw(3);
      idle(4);
      check_lit("cancel_edit_val", value_out, 9);
      s_short = n_short; s_long = n_long;
      press(300);
      check_lit("cancel_long_pulse", n_long - s_long, 1);
      check_lit("cancel_no_short", n_short - s_short, 0);
      check_lit("cancel_val", value_out, 5);
      check_lit("cancel_mode", edit_mode, 0);

      // Bounce rejection, then everything ignored while ena is low
      s_short = n_short; s_long = n_long;
      repeat (20) begin
         btn_n = ~btn_n;
         idle(3);
      end
      btn_n = 1'b1;
      idle(DEB + 10);
      check_lit("bounce_pulses", (n_short - s_short) + (n_long - s_long), 0);
      ena = 1'b0;
      s_step = n_step; s_short = n_short;
      cw(10);
      press(40);
      check_lit("ena_low_pulses", (n_step - s_step) + (n_short - s_short), 0);
      check_lit("ena_low_sel", sel, 1);
      check_lit("ena_low_mode", edit_mode, 0);
      ena = 1'b1;

      // Async reset in the middle of an edit
      cw(3);
      press(40);
      repeat (7) cw(3);
      idle(4);
      check_lit("pre_reset_sel", sel, 2);
      check_lit("pre_reset_val", value_out, 7);
      check_lit("pre_reset_mode", edit_mode, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_lit("async_rst_sel", sel, 0);
      check_lit("async_rst_val", value_out, 0);
      check_lit("async_rst_mode", edit_mode, 0);
      check_lit("async_rst_dir", step_dir, 1);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Randomized traffic against the model
      for (int i = 0; i < 150; i++) begin
         ena = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 5))
            0: cw($urandom_range(2, 5));
            1: ccw($urandom_range(2, 5));
            2: press($urandom_range(5, 320));
            3: begin
               enc_a = 1'($urandom_range(0, 1));
               enc_b = 1'($urandom_range(0, 1));
               idle($urandom_range(1, 4));
            end
            4: begin
               btn_n = 1'($urandom_range(0, 1));
               idle($urandom_range(1, 30));
            end
            default: begin
               @(posedge clk);
               #2 rst_n = 1'b0;
               idle(1);
               rst_n = 1'b1;
               idle(1);
            end
         endcase
      end
      btn_n = 1'b1;
      idle(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
